// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default program counter loaded on reset
//   fetch_state_t    : fetch FSM states
//     REQ  - read request presented to instruction memory
//     WAIT - request accepted, waiting for its response
//     HOLD - instruction buffered and offered to decode
//     DROP - waiting for a response that must be discarded
package riscv_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RV32I core.
// Owns the architectural PC, keeps at most one instruction-memory read in
// flight, buffers the returned word for decode and accepts redirects from
// execute. The +4 adder lives in the parent: pc goes out, pcplus4 comes back.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc, pcplus4       : current PC to the adder, pc+4 back from it
//   redirect_valid/_target : PC change request from execute (highest priority)
//   imem_req_*        : read request channel (addr == pc)
//   imem_rsp_*        : read response channel, one per accepted request, in order
//   if_valid/_instr/_pc, if_ready : instruction handoff to decode
//   misaligned        : one-cycle registered pulse, redirect target had [1:0]!=0
//   state_dbg         : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends combinationally on ready. The request side
// is the one exception to "valid holds until accepted": a redirect may change
// imem_req_addr (or drop imem_req_valid for reset) before acceptance.
module fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcplus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            misaligned,
  output fetch_state_t    state_dbg
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic            mis_q, mis_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    mis_d   = 1'b0;

    unique case (state_q)
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          ifpc_d  = pc_q;
          pc_d    = pcplus4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (if_ready) state_d = REQ;
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides everything above. A request already accepted (this
    // cycle or earlier) still owes a response, which DROP swallows. The
    // holding register keeps its old contents; it is simply no longer valid.
    if (redirect_valid) begin
      pc_d    = {redirect_target[XLEN-1:2], 2'b00};
      mis_d   = |redirect_target[1:0];
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      unique case (state_q)
        REQ:     state_d = imem_req_ready ? DROP : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ  : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rsp_valid ? REQ  : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  assign pc             = pc_q;
  assign imem_req_valid = (state_q == REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = ifpc_q;
  assign misaligned     = mis_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reactive instruction memory, a PC reference model
// and a scoreboard queue of instructions decode is expected to receive.
module tb_fetch_stage;
  import riscv_fetch_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  pc, pcplus4;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_target = '0;
  logic         imem_req_valid;
  logic [31:0]  imem_req_addr;
  logic         imem_req_ready = 1'b0;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data = '0;
  logic         if_valid;
  logic [31:0]  if_instr, if_pc;
  logic         if_ready = 1'b0;
  logic         misaligned;
  fetch_state_t state_dbg;

  // the external +4 adder
  assign pcplus4 = pc + 32'd4;

  fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pcplus4(pcplus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .misaligned(misaligned),
    .state_dbg(state_dbg)
  );

  // ---------------- knobs ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_hs = 0;
  int          rdy_pct = 100, ifr_pct = 100, lat_lo = 1, lat_hi = 1;
  int          redir_mode = 0;   // 0 none,1 now,2 on accept,3 in WAIT,4 on rsp,5 random
  int          redir_pct = 0;
  logic [31:0] redir_tgt = '0;
  bit          fired = 0;
  bit          rst_req = 1'b1;

  // ---------------- memory + reference model ----------------
  bit          mb_busy = 0, mb_killed = 0;
  int          mb_cnt = 0;
  logic [31:0] mb_addr = '0, mb_exp_addr = '0;
  logic [31:0] model_pc = TB_RESET_PC;
  logic        exp_mis = 1'b0;
  logic [63:0] exp_q[$];

  // samples of the last cycle
  logic        smp_req_valid, smp_if_valid, smp_mis, smp_accept;
  logic [31:0] smp_req_addr, smp_pc, smp_if_instr, smp_if_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive at negedge, sample/check/update model, wait posedge.
  task automatic do_cycle();
    bit          accept, rsp, redir, hs;
    logic [63:0] e;
    @(negedge clk);
    rst            = rst_req;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
    rsp            = !rst && mb_busy && (mb_cnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mb_addr) : $urandom;
    #1;
    accept = imem_req_valid && imem_req_ready;
    redir  = 0;
    case (redir_mode)
      1: redir = 1;
      2: redir = accept;
      3: redir = mb_busy && !mb_killed && !rsp;
      4: redir = rsp;
      5: begin
        redir     = ($urandom_range(99) < redir_pct);
        redir_tgt = $urandom & 32'h0000_0FFF;
      end
      default: redir = 0;
    endcase
    if (rst) redir = 0;
    if (redir && redir_mode != 5) begin
      fired      = 1;
      redir_mode = 0;
    end
    redirect_valid  = redir;
    redirect_target = redir ? redir_tgt : $urandom;
    #1;
    smp_req_valid = imem_req_valid; smp_req_addr = imem_req_addr;
    smp_if_valid  = if_valid;       smp_if_instr = if_instr;
    smp_if_pc     = if_pc;          smp_mis      = misaligned;
    smp_pc        = pc;             smp_accept   = accept;

    if (rst) begin
      mb_busy = 0; mb_killed = 0; mb_cnt = 0;
      exp_q.delete();
      model_pc = TB_RESET_PC;
      exp_mis  = 1'b0;
    end else begin
      n_checks++;
      if (pc !== model_pc) begin
        n_errors++; $display("FAIL pc: got %h expected %h", pc, model_pc);
      end
      n_checks++;
      if (if_valid !== (exp_q.size() != 0)) begin
        n_errors++; $display("FAIL if_valid: got %b expected %b", if_valid, exp_q.size() != 0);
      end
      n_checks++;
      if (misaligned !== exp_mis) begin
        n_errors++; $display("FAIL misaligned: got %b expected %b", misaligned, exp_mis);
      end
      n_checks++;
      if (imem_req_valid !== (!mb_busy && exp_q.size() == 0)) begin
        n_errors++;
        $display("FAIL req_valid: got %b expected %b", imem_req_valid, !mb_busy && exp_q.size() == 0);
      end

      hs = (exp_q.size() != 0) && if_ready;
      if (hs) begin
        e = exp_q.pop_front();
        n_hs++;
        n_checks++;
        if ({if_pc, if_instr} !== e) begin
          n_errors++;
          $display("FAIL handoff: got pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, if_instr, e[63:32], e[31:0]);
        end
      end else if (redir && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end

      if (rsp) begin
        mb_busy = 0;
        if (!mb_killed && !redir) begin
          exp_q.push_back({mb_exp_addr, mem_word(mb_exp_addr)});
          model_pc = mb_exp_addr + 32'd4;
        end
      end else if (mb_busy) begin
        if (redir) mb_killed = 1;
        mb_cnt--;
      end

      if (accept) begin
        n_checks++;
        if (imem_req_addr !== model_pc) begin
          n_errors++; $display("FAIL req_addr: got %h expected %h", imem_req_addr, model_pc);
        end
        mb_busy     = 1;
        mb_addr     = imem_req_addr;
        mb_exp_addr = model_pc;
        mb_cnt      = $urandom_range(lat_hi, lat_lo) - 1;
        mb_killed   = redir;
      end

      if (redir) model_pc = {redirect_target[31:2], 2'b00};
      exp_mis = redir && (|redirect_target[1:0]);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    do_cycle();
    do_cycle();
    rst_req = 1'b0;
  endtask

  task automatic cfg(input int rdy, input int ifr, input int lo, input int hi);
    rdy_pct = rdy; ifr_pct = ifr; lat_lo = lo; lat_hi = hi;
    redir_mode = 0; redir_pct = 0; fired = 0;
  endtask

  task automatic wait_fired(input string name);
    for (int i = 0; i < 30 && !fired; i++) do_cycle();
    n_checks++;
    if (!fired) begin
      n_errors++; $display("FAIL %s_timeout: got no redirect expected one", name);
    end
  endtask

  task automatic wait_accept(input string name);
    do_cycle();
    for (int i = 0; i < 30 && !smp_accept; i++) do_cycle();
    n_checks++;
    if (!smp_accept) begin
      n_errors++; $display("FAIL %s_timeout: got no request accept expected one", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cfg(100, 100, 1, 1);
    do_reset();
    n_checks++;
    if (smp_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %b expected 0", smp_req_valid); end
    n_checks++;
    if (smp_pc !== TB_RESET_PC) begin n_errors++; $display("FAIL rst_pc: got %h expected %h", smp_pc, TB_RESET_PC); end
    n_checks++;
    if ({smp_if_valid, smp_if_instr, smp_if_pc, smp_mis} !== 66'd0) begin
      n_errors++; $display("FAIL rst_outputs: got v=%b i=%h p=%h m=%b expected all 0",
                           smp_if_valid, smp_if_instr, smp_if_pc, smp_mis);
    end
    do_cycle();
    n_checks++;
    if (smp_req_valid !== 1'b1 || smp_req_addr !== TB_RESET_PC) begin
      n_errors++; $display("FAIL first_req: got v=%b a=%h expected 1 %h", smp_req_valid, smp_req_addr, TB_RESET_PC);
    end
  endtask

  task automatic test_basic();
    int h0;
    cfg(100, 100, 1, 1);
    do_reset();
    h0 = n_hs;
    do_cycle(); do_cycle(); do_cycle();
    n_checks++;
    if (smp_if_valid !== 1'b1 || smp_if_pc !== 32'h0 || smp_if_instr !== 32'h0000_0013) begin
      n_errors++; $display("FAIL first_instr: got v=%b pc=%h i=%h expected 1 00000000 00000013",
                           smp_if_valid, smp_if_pc, smp_if_instr);
    end
    repeat (27) do_cycle();
    n_checks++;
    if (n_hs - h0 !== 10) begin
      n_errors++; $display("FAIL throughput: got %0d expected 10", n_hs - h0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] si, sp;
    cfg(100, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 20 && !smp_if_valid; i++) do_cycle();
    si = smp_if_instr; sp = smp_if_pc;
    repeat (5) begin
      do_cycle();
      n_checks++;
      if (smp_if_instr !== si || smp_if_pc !== sp || smp_req_valid !== 1'b0 || smp_if_valid !== 1'b1) begin
        n_errors++; $display("FAIL stall_hold: got i=%h p=%h rv=%b v=%b expected %h %h 0 1",
                             smp_if_instr, smp_if_pc, smp_req_valid, smp_if_valid, si, sp);
      end
    end
    ifr_pct = 100;
    do_cycle();
    do_cycle();
    n_checks++;
    if (smp_req_valid !== 1'b1 || smp_req_addr !== sp + 32'd4) begin
      n_errors++; $display("FAIL stall_release: got v=%b a=%h expected 1 %h", smp_req_valid, smp_req_addr, sp + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    int h0;
    cfg(100, 100, 3, 3);
    do_reset();
    redir_tgt = 32'h0000_0100; redir_mode = 3;
    wait_fired("redir_wait");
    h0 = n_hs;
    wait_accept("redir_wait");
    n_checks++;
    if (smp_req_addr !== 32'h0000_0100 || n_hs !== h0) begin
      n_errors++; $display("FAIL redir_wait: got a=%h hs=%0d expected 00000100 hs=%0d", smp_req_addr, n_hs, h0);
    end
  endtask

  task automatic test_misaligned();
    cfg(100, 100, 1, 1);
    do_reset();
    redir_tgt = 32'h0000_0102; redir_mode = 1;
    do_cycle();
    do_cycle();
    n_checks++;
    if (smp_mis !== 1'b1) begin n_errors++; $display("FAIL mis_pulse: got %b expected 1", smp_mis); end
    do_cycle();
    n_checks++;
    if (smp_mis !== 1'b0) begin n_errors++; $display("FAIL mis_clear: got %b expected 0", smp_mis); end
    n_checks++;
    if (smp_req_valid !== 1'b1 || smp_req_addr !== 32'h0000_0100) begin
      n_errors++; $display("FAIL mis_addr: got v=%b a=%h expected 1 00000100", smp_req_valid, smp_req_addr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    cfg(100, 100, 1, 1);
    do_reset();
    redir_tgt = 32'h0000_0200; redir_mode = 4;
    wait_fired("redir_rsp");
    do_cycle();
    n_checks++;
    if (smp_req_valid !== 1'b1 || smp_req_addr !== 32'h0000_0200 || smp_if_valid !== 1'b0) begin
      n_errors++; $display("FAIL redir_rsp: got rv=%b a=%h v=%b expected 1 00000200 0",
                           smp_req_valid, smp_req_addr, smp_if_valid);
    end
    cfg(100, 100, 2, 2);
    do_reset();
    redir_tgt = 32'h0000_0300; redir_mode = 2;
    wait_fired("redir_acc");
    repeat (2) begin
      do_cycle();
      n_checks++;
      if (smp_req_valid !== 1'b0 || smp_if_valid !== 1'b0) begin
        n_errors++; $display("FAIL redir_acc_drop: got rv=%b v=%b expected 0 0", smp_req_valid, smp_if_valid);
      end
    end
    do_cycle();
    n_checks++;
    if (smp_req_valid !== 1'b1 || smp_req_addr !== 32'h0000_0300) begin
      n_errors++; $display("FAIL redir_acc_req: got v=%b a=%h expected 1 00000300", smp_req_valid, smp_req_addr);
    end
  endtask

  task automatic test_wrap();
    cfg(100, 100, 1, 1);
    do_reset();
    redir_tgt = 32'hFFFF_FFFC; redir_mode = 1;
    do_cycle();
    wait_accept("wrap_first");
    n_checks++;
    if (smp_req_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_first: got %h expected fffffffc", smp_req_addr);
    end
    wait_accept("wrap_next");
    n_checks++;
    if (smp_req_addr !== 32'h0000_0000) begin
      n_errors++; $display("FAIL wrap_next: got %h expected 00000000", smp_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    cfg(100, 100, 10, 10);
    do_reset();
    do_cycle(); do_cycle(); do_cycle();
    rst_req = 1'b1;
    do_cycle();
    rst_req = 1'b0;
    do_cycle();
    n_checks++;
    if (smp_pc !== TB_RESET_PC || smp_if_valid !== 1'b0 || smp_req_valid !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid: got pc=%h v=%b rv=%b expected %h 0 1",
                           smp_pc, smp_if_valid, smp_req_valid, TB_RESET_PC);
    end
    lat_lo = 1; lat_hi = 3;
    repeat (20) do_cycle();
  endtask

  task automatic test_random();
    int h0;
    cfg(70, 60, 1, 4);
    do_reset();
    h0 = n_hs;
    redir_mode = 5; redir_pct = 6;
    repeat (400) do_cycle();
    cfg(100, 100, 1, 2);
    repeat (20) do_cycle();
    n_checks++;
    if (n_hs - h0 < 10) begin
      n_errors++; $display("FAIL random_progress: got %0d handoffs expected at least 10", n_hs - h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_misaligned();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core. It owns the architectural program counter and issues one outstanding instruction-memory read at a time. It hands each fetched instruction and its address to decode over a valid/ready handshake, and accepts branch/jump redirects from execute. It drives the PC into the existing +4 adder and consumes that adder's result as the sequential next PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc  out  32  current fetch PC, fed to the +4 adder
- pcplus4  in  32  pc + 4 from the adder, the sequential next PC
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_target  in  32  new PC for the redirect
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  32  read address, equal to pc
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  read data valid; exactly one response per accepted request, in order
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  fetched instruction available to decode
- if_instr  out  32  instruction word
- if_pc  out  32  address of if_instr
- if_ready  in  1  decode accepts the instruction
- misaligned  out  1  one-cycle registered pulse: redirect_target[1:0] was nonzero

## Operation
- The FSM has four states: REQ (request outstanding to memory), WAIT (accepted, awaiting response), HOLD (instruction buffered for decode), DROP (awaiting a response to be discarded).
- imem_req_valid = (state==REQ) and not rst. imem_req_addr = pc.
- if_valid = (state==HOLD).
- REQ: when imem_req_ready, go to WAIT.
- WAIT: when imem_rsp_valid:
  - if_instr <= imem_rsp_data and if_pc <= pc.
  - pc <= pcplus4.
  - Go to HOLD.
- HOLD: when if_ready, go to REQ.
- DROP: imem_req_valid=0. When imem_rsp_valid, discard the data and go to REQ.
- Redirect has highest priority over every transition above. On redirect_valid:
  - pc <= {redirect_target[31:2], 2'b00}.
  - misaligned <= |redirect_target[1:0].
  - Any buffered instruction is dropped and any captured response is not presented to decode.
- Next state under redirect:
  - REQ with imem_req_ready this cycle: go to DROP.
  - REQ without imem_req_ready: stay in REQ.
  - WAIT with imem_rsp_valid this cycle: go to REQ, response discarded.
  - WAIT without imem_rsp_valid: go to DROP.
  - HOLD, including when if_ready is high the same cycle: go to REQ. The handshake that cycle does complete, because decode saw valid; execute must squash younger instructions itself.
  - DROP with imem_rsp_valid this cycle: go to REQ.
  - DROP without imem_rsp_valid: stay in DROP.
- Memory contract: a redirect may change imem_req_addr while a request is pending and not yet accepted. imem must tolerate this withdrawal.
- PC arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and needs no special handling. pc[1:0] is always 0.

## Timing
- Reset values: pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=0, misaligned=0. imem_req_valid is 0 during the reset cycle and 1 in the first cycle after.
- Reset mid-operation abandons any outstanding request. The memory system is reset on the same rst.
- Minimum latency is 2 cycles from request acceptance to if_valid: response in the cycle after acceptance, if_valid the cycle after that.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- The first request after a redirect carries the new address in the cycle after redirect_valid.

## Structure
- Shared package riscv_fetch_pkg holds:
  - the fetch_state_t enum (REQ, WAIT, HOLD, DROP);
  - the RESET_PC default;
  - an XLEN=32 constant.
- No sub-module. The +4 adder stays outside and is connected at the parent. The holding register is inline.

## Test plan
- Reset, memory always ready, response 1 cycle later with data 32'h00000013 → if_valid=1 with if_pc=0. The next request carries addr 4.
- Decode holds if_ready=0 for 5 cycles → if_instr and if_pc unchanged. No new imem request until after the handshake.
- Redirect to 32'h0000_0100 while in WAIT, response arriving 2 cycles later → that response is never presented to decode. The next request carries addr 32'h100.
- Redirect to 32'h0000_0102 → misaligned pulses for 1 cycle. The next request carries addr 32'h100.
- Redirect in the same cycle as imem_rsp_valid in WAIT, and separately in the same cycle as imem_req_ready in REQ → the state transitions listed in Operation are followed, and exactly one response is dropped per accepted request.
- pc=32'hFFFF_FFFC fetched → the next request carries addr 32'h0000_0000. Reset asserted while in WAIT → pc=RESET_PC and if_valid=0 on the next cycle.
